// File: rtl/cbus_ram_responder_pkg.sv
// Shared cache-bus types, burst encodings and the next-address helper.
// The stall feature of the responder (CBUS_RAM_RANDOM_STALL_EN) needs nothing extra here.
package cbus_ram_responder_pkg;

  typedef logic [1:0]  u2;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [2:0]  msize_t;
  typedef logic [7:0]  mlen_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED    = 2'd0,
    AXI_BURST_INCR     = 2'd1,
    AXI_BURST_WRAP     = 2'd2,
    AXI_BURST_RESERVED = 2'd3
  } axi_burst_type_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  // len field holds beat count minus one
  localparam mlen_t MLEN1  = 8'd0;
  localparam mlen_t MLEN2  = 8'd1;
  localparam mlen_t MLEN4  = 8'd3;
  localparam mlen_t MLEN8  = 8'd7;
  localparam mlen_t MLEN16 = 8'd15;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  typedef enum u2 {CRAM_IDLE, CRAM_WAIT, CRAM_BURST, CRAM_DONE} cram_state_t;

  function automatic addr_t cbus_next_addr(addr_t addr, msize_t size, mlen_t len,
                                           axi_burst_type_t burst);
    addr_t step;
    addr_t blk;
    addr_t next;
    step = addr_t'(1) << size;
    blk  = (addr_t'(len) + addr_t'(1)) << size;
    case (burst)
      AXI_BURST_FIXED: next = addr;
      AXI_BURST_WRAP:  next = (addr & ~(blk - addr_t'(1))) | ((addr + step) & (blk - addr_t'(1)));
      default:         next = addr + step;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/cbus_burst_addr_gen.sv
// Combinational next-address unit for FIXED/INCR/WRAP bursts.
// Kept standalone so an AXI bridge can share it.
module cbus_burst_addr_gen
  import cbus_ram_responder_pkg::*;
(
  input  addr_t           addr,
  input  msize_t          size,
  input  mlen_t           len,
  input  axi_burst_type_t burst,
  output addr_t           next_addr
);

  assign next_addr = cbus_next_addr(addr, size, len, burst);

endmodule

// File: rtl/cbus_ram_responder.sv
// Cache-bus memory responder: single-port word RAM, programmable first-beat latency,
// FIXED/INCR/WRAP bursts. Define CBUS_RAM_RANDOM_STALL_EN for LFSR-driven ready stalls.
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

  cram_state_t     state;
  addr_t           cur_addr;
  msize_t          cur_size;
  mlen_t           cur_len;
  axi_burst_type_t cur_burst;
  logic            cur_write;
  mlen_t           cnt;
  logic [3:0]      lat_cnt;

  addr_t           next_addr;
  logic [AW-1:0]   idx;
  logic            stall;
  logic            beat;

  word_t mem [DEPTH];

  cbus_burst_addr_gen u_addr_gen (
    .addr      (cur_addr),
    .size      (cur_size),
    .len       (cur_len),
    .burst     (cur_burst),
    .next_addr (next_addr)
  );

`ifdef CBUS_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall       = 1'b0;
`endif

  // Dropping valid mid-burst suppresses the beat immediately, so no stray write lands.
  assign beat = (state == CRAM_BURST) && creq.valid && !stall;
  assign idx  = cur_addr[3 +: AW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CRAM_IDLE;
      cur_addr  <= '0;
      cur_size  <= '0;
      cur_len   <= '0;
      cur_burst <= AXI_BURST_FIXED;
      cur_write <= 1'b0;
      cnt       <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        CRAM_IDLE: begin
          if (creq.valid) begin
            cur_addr  <= creq.addr;
            cur_size  <= creq.size;
            cur_len   <= creq.len;
            cur_burst <= creq.burst;
            cur_write <= creq.is_write;
            cnt       <= '0;
            lat_cnt   <= LAT_INIT;
            state     <= (LATENCY == 0) ? CRAM_BURST : CRAM_WAIT;
          end
        end
        CRAM_WAIT: begin
          if (!creq.valid) begin
            state <= CRAM_IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) state <= CRAM_BURST;
          end
        end
        CRAM_BURST: begin
          if (!creq.valid) begin
            state <= CRAM_IDLE;
          end else if (beat) begin
            cnt      <= cnt + mlen_t'(1);
            cur_addr <= next_addr;
            if (cnt == cur_len) state <= CRAM_DONE;
          end
        end
        CRAM_DONE: begin
          if (!creq.valid) state <= CRAM_IDLE;
        end
        default: state <= CRAM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat && cur_write) begin
      for (int k = 0; k < 8; k++) begin
        if (creq.strobe[k]) mem[idx][8*k +: 8] <= creq.data[8*k +: 8];
      end
    end
  end

  always_comb begin
    cresp       = '0;
    cresp.ready = beat;
    cresp.last  = beat && (cnt == cur_len);
    if (beat && !cur_write) cresp.data = mem[idx];
  end

endmodule
